// File: rtl/alu_fu_pipe_pkg.sv
//==== alu_pkg | optype encodings and helpers shared by the ALU functional unit | rev 1.0
//==== used by alu_fu_pipe_if, alu_fu_core and alu_fu_pipe
`default_nettype none

package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'd2;
  localparam logic [OP_W-1:0] OP_LUI  = 4'd3;
  localparam logic [OP_W-1:0] OP_ORI  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRAI = 4'd6;
  localparam logic [OP_W-1:0] OP_LB   = 4'd7;
  localparam logic [OP_W-1:0] OP_LW   = 4'd8;
  localparam logic [OP_W-1:0] OP_SB   = 4'd9;
  localparam logic [OP_W-1:0] OP_SW   = 4'd10;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LW) || (op == OP_SB) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_fu_pipe_if.sv
//==== alu_fu_pipe_if | issue-side and writeback-side handshake bundle for one ALU slot | rev 1.0
//==== master = issue/writeback environment, slave = the functional unit
`default_nettype none

interface alu_fu_pipe_if
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int ROB_W   = 6,
  parameter int NUM_ALU = 3
);

  logic               flush;
  logic               issue_valid;
  logic [NUM_ALU-1:0] issue_sel;
  logic               issue_ready;
  logic [OP_W-1:0]    optype;
  logic [XLEN-1:0]    src1;
  logic [XLEN-1:0]    src2;
  logic [XLEN-1:0]    imm;
  logic [TAG_W-1:0]   dest_tag;
  logic [ROB_W-1:0]   rob_idx;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [XLEN-1:0]    out_st_data;
  logic [OP_W-1:0]    out_optype;
  logic [TAG_W-1:0]   out_tag;
  logic [ROB_W-1:0]   out_rob_idx;
  logic               out_illegal;

  modport master (
    output flush, issue_valid, issue_sel, optype, src1, src2, imm, dest_tag, rob_idx, out_ready,
    input  issue_ready, out_valid, out_result, out_st_data, out_optype, out_tag, out_rob_idx,
           out_illegal
  );

  modport slave (
    input  flush, issue_valid, issue_sel, optype, src1, src2, imm, dest_tag, rob_idx, out_ready,
    output issue_ready, out_valid, out_result, out_st_data, out_optype, out_tag, out_rob_idx,
           out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/alu_fu_pipe_core.sv
//==== alu_fu_core | combinational ALU datapath: result or memory address, plus illegal flag | rev 1.0
//==== no state; sits at the entry of the alu_fu_pipe slot array
`default_nettype none

module alu_fu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] optype,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (optype)
      OP_ADD:  result = src1 + src2;
      OP_ADDI: result = src1 + imm;
      OP_LUI:  result = imm;
      OP_ORI:  result = src1 | imm;
      OP_XOR:  result = src1 ^ src2;
      OP_SRAI: result = $unsigned($signed(src1) >>> imm[4:0]);
      default: begin
        // loads and stores share the base+offset adder; anything else is illegal with a zero result
        if (is_mem_op(optype)) result = src1 + imm;
        else                   illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_fu_pipe.sv
//==== alu_fu_pipe | pipelined ALU FU: STAGES-deep slot array, valid/ready, flush | rev 1.0
//==== optional: define ALU_FU_PERF_EN for perf_issued/perf_stall/perf_flushed counters
`default_nettype none

module alu_fu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int ROB_W   = 6,
  parameter int NUM_ALU = 3,
  parameter int ALU_ID  = 0,
  parameter int STAGES  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  alu_fu_pipe_if.slave bus
`ifdef ALU_FU_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flushed
`endif
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] free;
  logic [XLEN-1:0]   res_a [STAGES];
  logic [XLEN-1:0]   st_a  [STAGES];
  logic [OP_W-1:0]   op_a  [STAGES];
  logic [TAG_W-1:0]  tag_a [STAGES];
  logic [ROB_W-1:0]  rob_a [STAGES];
  logic [STAGES-1:0] ill_a;

  logic [XLEN-1:0]   core_res;
  logic              core_ill;
  logic              accept;

  alu_fu_core #(.XLEN(XLEN)) u_core (
    .optype  (bus.optype),
    .src1    (bus.src1),
    .src2    (bus.src2),
    .imm     (bus.imm),
    .result  (core_res),
    .illegal (core_ill)
  );

  // A slot can take new data when it is empty or its content moves on this edge
  always_comb begin
    logic f;
    free    = '0;
    f       = ~vld[LAST] | bus.out_ready;
    free[LAST] = f;
    for (int i = LAST - 1; i >= 0; i--) begin
      f       = ~vld[i] | f;
      free[i] = f;
    end
  end

  assign bus.issue_ready = rstn & ~bus.flush & free[0];
  assign accept          = bus.issue_valid & bus.issue_sel[ALU_ID] & bus.issue_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic             v_d,   v_q;
    logic [XLEN-1:0]  res_d, res_q;
    logic [XLEN-1:0]  st_d,  st_q;
    logic [OP_W-1:0]  op_d,  op_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [ROB_W-1:0] rob_d, rob_q;
    logic             ill_d, ill_q;

    if (i == 0) begin : g_head
      assign v_d   = accept;
      assign res_d = core_res;
      assign st_d  = bus.src2;
      assign op_d  = bus.optype;
      assign tag_d = bus.dest_tag;
      assign rob_d = bus.rob_idx;
      assign ill_d = core_ill;
    end else begin : g_body
      assign v_d   = vld[i-1];
      assign res_d = res_a[i-1];
      assign st_d  = st_a[i-1];
      assign op_d  = op_a[i-1];
      assign tag_d = tag_a[i-1];
      assign rob_d = rob_a[i-1];
      assign ill_d = ill_a[i-1];
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        v_q   <= 1'b0;
        res_q <= '0;
        st_q  <= '0;
        op_q  <= '0;
        tag_q <= '0;
        rob_q <= '0;
        ill_q <= 1'b0;
      end else begin
        if (bus.flush)   v_q <= 1'b0;
        else if (free[i]) v_q <= v_d;
        if (free[i]) begin
          res_q <= res_d;
          st_q  <= st_d;
          op_q  <= op_d;
          tag_q <= tag_d;
          rob_q <= rob_d;
          ill_q <= ill_d;
        end
      end
    end

    assign vld[i]   = v_q;
    assign res_a[i] = res_q;
    assign st_a[i]  = st_q;
    assign op_a[i]  = op_q;
    assign tag_a[i] = tag_q;
    assign rob_a[i] = rob_q;
    assign ill_a[i] = ill_q;
  end

  assign bus.out_valid   = vld[LAST];
  assign bus.out_result  = res_a[LAST];
  assign bus.out_st_data = st_a[LAST];
  assign bus.out_optype  = op_a[LAST];
  assign bus.out_tag     = tag_a[LAST];
  assign bus.out_rob_idx = rob_a[LAST];
  assign bus.out_illegal = ill_a[LAST];

`ifdef ALU_FU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_issued  <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (accept)                           perf_issued  <= perf_issued + 32'd1;
      if (bus.out_valid && !bus.out_ready)  perf_stall   <= perf_stall + 32'd1;
      if (bus.flush)                        perf_flushed <= perf_flushed + 32'($countones(vld));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_fu_pipe.sv
//==== tb_alu_fu_pipe | directed bench with queue-based reference model for alu_fu_pipe | rev 1.0
//==== connects the perf ports when ALU_FU_PERF_EN is defined
`default_nettype none

module tb_alu_fu_pipe;
  import alu_pkg::*;

  localparam int XLEN = 32, TAG_W = 6, ROB_W = 6, NUM_ALU = 3, STAGES = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_fu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W), .NUM_ALU(NUM_ALU)) bus ();

`ifdef ALU_FU_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_flushed;
`endif

  alu_fu_pipe #(
    .XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W), .NUM_ALU(NUM_ALU), .ALU_ID(0), .STAGES(STAGES)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef ALU_FU_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall),
    .perf_flushed (perf_flushed)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic        ill;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          pops    = 0;
  int          stalled = 0;
  logic [31:0] last_pop = '0;
  bit          chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [31:0] imm);
    logic [31:0] r;
    int          sh;
    sh = int'(imm[4:0]);
    case (op)
      4'd1:                    r = s1 + s2;
      4'd2, 4'd7, 4'd8, 4'd9, 4'd10: r = s1 + imm;
      4'd3:                    r = imm;
      4'd4:                    r = s1 | imm;
      4'd5:                    r = s1 ^ s2;
      4'd6: begin
        r = s1 >> sh;
        if (s1[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      default:                 r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit model_valid();
    return (q.size() > 0) && ((cyc - q[0].acc) >= STAGES);
  endfunction

  // Model: an op is visible at the tail once it is STAGES cycles old and at the head of the queue
  always @(posedge clk) begin : p_model
    bit   mr;
    exp_t e;
    if (!rstn || bus.flush) begin
      q.delete();
    end else begin
      mr = (q.size() < STAGES) || bus.out_ready;
      if (model_valid() && bus.out_ready) begin
        last_pop = q[0].res;
        pops++;
        void'(q.pop_front());
      end
      if (bus.issue_valid && bus.issue_sel[0] && mr) begin
        e.res = model_res(bus.optype, bus.src1, bus.src2, bus.imm);
        e.st  = bus.src2;
        e.op  = bus.optype;
        e.tag = bus.dest_tag;
        e.rob = bus.rob_idx;
        e.ill = !(bus.optype >= 4'd1 && bus.optype <= 4'd10);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : p_compare
    bit mv;
    if (chk_en) begin
      mv = model_valid();
      check("issue_ready", 64'(bus.issue_ready),
            64'(rstn && !bus.flush && ((q.size() < STAGES) || bus.out_ready)));
      check("out_valid", 64'(bus.out_valid), 64'(mv));
      if (mv) begin
        check("out_result",  64'(bus.out_result),  64'(q[0].res));
        check("out_st_data", 64'(bus.out_st_data), 64'(q[0].st));
        check("out_optype",  64'(bus.out_optype),  64'(q[0].op));
        check("out_tag",     64'(bus.out_tag),     64'(q[0].tag));
        check("out_rob_idx", 64'(bus.out_rob_idx), 64'(q[0].rob));
        check("out_illegal", 64'(bus.out_illegal), 64'(q[0].ill));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] imm, input logic [5:0] tag, input logic [5:0] rob);
    int n;
    n = 0;
    bus.issue_valid = 1'b1;
    bus.issue_sel   = 3'b001;
    bus.optype      = op;
    bus.src1        = s1;
    bus.src2        = s2;
    bus.imm         = imm;
    bus.dest_tag    = tag;
    bus.rob_idx     = rob;
    @(negedge clk);
    while (!bus.issue_ready && n < 20) begin
      n++;
      stalled++;
      @(negedge clk);
    end
    if (n >= 20) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  logic [3:0]  vop  [9] = '{4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd0, 4'd11, 4'd15};
  logic [31:0] vs1  [9] = '{32'hFFFF_FFFF, 32'h0F0F_0000, 32'hAAAA_5555, 32'h1000, 32'h2000,
                            32'h3000, 32'h5, 32'h6, 32'h7};
  logic [31:0] vs2  [9] = '{32'h1, 32'h2, 32'hFFFF_0000, 32'h4, 32'h5, 32'h66, 32'h7, 32'h8, 32'h9};
  logic [31:0] vimm [9] = '{32'h1, 32'h0000_00F0, 32'h0, 32'hFFFF_FFFF, 32'h8, 32'h10, 32'h1, 32'h2, 32'h3};

  initial begin : p_main
    int p0;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_sel   = 3'b001;
    bus.optype      = '0;
    bus.src1        = '0;
    bus.src2        = '0;
    bus.imm         = '0;
    bus.dest_tag    = '0;
    bus.rob_idx     = '0;
    bus.out_ready   = 1'b1;

    // reset state
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid",   64'(bus.out_valid),   64'd0);
    check("rst_out_result",  64'(bus.out_result),  64'd0);
    check("rst_issue_ready", 64'(bus.issue_ready), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rel_issue_ready", 64'(bus.issue_ready), 64'd1);

    // ADD latency and result
    @(posedge clk);
    #1;
    send(OP_ADD, 32'd5, 32'd7, 32'd0, 6'd3, 6'd1);
    @(negedge clk);
    check("t1_valid_c1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c2", 64'(bus.out_valid),  64'd1);
    check("t1_result",   64'(bus.out_result), 64'd12);
    check("t1_tag",      64'(bus.out_tag),    64'd3);

    // SRAI then LUI back to back
    @(posedge clk);
    #1;
    send(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 6'd4, 6'd2);
    send(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 6'd5, 6'd3);
    @(negedge clk);
    check("t2_srai", 64'(bus.out_result), 64'hF800_0000);
    @(negedge clk);
    check("t2_lui",  64'(bus.out_result), 64'h1234_5000);

    // SW address and store data
    send(OP_SW, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 6'd6, 6'd4);
    repeat (2) @(negedge clk);
    check("t3_addr",  64'(bus.out_result),  64'hFC);
    check("t3_stdat", 64'(bus.out_st_data), 64'hDEAD);

    // remaining ops and illegal encodings, back to back
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) send(vop[i], vs1[i], vs2[i], vimm[i], 6'(10 + i), 6'(i));
    repeat (4) @(negedge clk);
    check("t_vec_drained", 64'(q.size()), 64'd0);

    // backpressure: 4 ADDs with the consumer stalled at first
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    stalled = 0;
    p0 = pops;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 4; i++) send(OP_ADD, 32'(i), 32'd100, 32'd0, 6'(20 + i), 6'(i));
    repeat (6) @(negedge clk);
    check("t4_stall_seen", 64'(stalled != 0), 64'd1);
    check("t4_pops",       64'(pops - p0),    64'd4);
    check("t4_last",       64'(last_pop),     64'd103);

    // flush with two in flight plus one offered
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, 32'd0, 6'd30, 6'd30);
    send(OP_ADD, 32'd2, 32'd2, 32'd0, 6'd31, 6'd31);
    p0 = pops;
    bus.issue_valid = 1'b1;
    bus.optype      = OP_ADD;
    bus.src1        = 32'd3;
    bus.flush       = 1'b1;
    @(negedge clk);
    check("t5_ready_in_flush", 64'(bus.issue_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    check("t5_valid_after", 64'(bus.out_valid),   64'd0);
    check("t5_ready_after", 64'(bus.issue_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("t5_valid_late", 64'(bus.out_valid), 64'd0);
    check("t5_no_pops",    64'(pops - p0),     64'd0);

    // op steered to another ALU slot
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b1;
    bus.issue_sel   = 3'b010;
    bus.optype      = OP_ADD;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.issue_sel   = 3'b001;
    repeat (3) @(negedge clk);
    check("t6_not_taken", 64'(bus.out_valid), 64'd0);

    // reset in the middle of traffic
    @(posedge clk);
    #1;
    send(OP_XOR, 32'hF0, 32'h0F, 32'd0, 6'd40, 6'd40);
    send(OP_ORI, 32'hF0, 32'd0, 32'h0F, 6'd41, 6'd41);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", 64'(bus.issue_ready), 64'd0);
    @(negedge clk);
    check("t6_rst_valid",  64'(bus.out_valid),  64'd0);
    check("t6_rst_result", 64'(bus.out_result), 64'd0);
    check("t6_rst_tag",    64'(bus.out_tag),    64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", 64'(bus.issue_ready), 64'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
